// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle MIPS sequencing controller with a bounded memory wait.
//            Define MC_JUMP_EN to build the JUMP state (opcode 000010).
// Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9
`ifdef MC_JUMP_EN
        ,
        JUMP     = 4'd10
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              in_wait;
    logic              timeout;
    logic              funct_ok;

    assign in_wait  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // A ready arriving on the expiry cycle completes normally instead of aborting.
    assign timeout  = in_wait && !mem_ready && (wait_cnt_q == CNT_MAX);
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                      (funct == FN_AND) || (funct == FN_OR);
    assign state_o  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_control   = ALU_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = timeout;

        // Staying in a wait state only happens on a not-ready, unexpired cycle.
        wait_cnt_d = (in_wait && !mem_ready && !timeout) ? wait_cnt_q + 1'b1 : '0;

        case (state_q)
            RESET: begin
                alu_control = 4'b0000;
                state_d     = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = EXEC_R;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = MEM_RD;
                end else if (opcode == OP_SW) begin
                    state_d = MEM_WR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout) begin
                    state_d = FETCH;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = !timeout;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if (timeout) begin
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
                state_d = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_control   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencing controller for the MIPS datapath. It replaces per-instruction single-cycle decode with a Moore-style state machine. It steps each instruction through fetch, decode, execute, memory and write-back, driving the shared ALU, the register file and the single unified memory port. It also waits on a memory-ready handshake, with a bounded timeout.

## Interface
- WAIT_MAX, 15: maximum cycles spent waiting for `mem_ready` in one memory state before abort (1..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  ALU B-input select: 00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
- alu_control  out  4  ALU op code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR.
- instr_done  out  1  one-cycle pulse on the last cycle of each completed instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct.
- mem_timeout  out  1  one-cycle pulse when the wait counter expires.
- state_o  out  4  current state encoding, for debug.

## Operation
- States and encodings: RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10.
- Any output not listed for a state is 0; `alu_control` defaults to 0010.
- RESET: all outputs 0. Advances to FETCH unconditionally on the first clock after `rst_n` deasserts.
- FETCH drives:
  - `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, ADD, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Transition: to DECODE when `mem_ready`=1, else stay.
- DECODE drives `alu_src_a`=0, `alu_src_b`=11, ADD. Transition by opcode:
  - 000000 with funct 100000/100010/100100/100101 → EXEC_R.
  - 100011 or 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - 000010 → JUMP (only when the macro is enabled).
  - Anything else, including an unknown funct: pulse `illegal_op` and go to FETCH.
- MEM_ADDR drives `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD drives `mem_read`=1, `i_or_d`=1. Goes to MEM_WB on `mem_ready`.
- MEM_WB drives `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, pulses `instr_done`. Goes to FETCH.
- MEM_WR drives `mem_write`=1, `i_or_d`=1. On `mem_ready`: pulse `instr_done`, go to FETCH.
- EXEC_R drives `alu_src_a`=1, `alu_src_b`=00, and `alu_control` from funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001.
- R_WB drives `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, pulses `instr_done`.
- BRANCH drives `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_write_cond`=1, `pc_source`=01, pulses `instr_done`.
- JUMP drives `pc_write`=1, `pc_source`=10, pulses `instr_done`.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR; increments each cycle spent there with `mem_ready`=0.
  - When it reaches WAIT_MAX with `mem_ready` still 0: pulse `mem_timeout`, assert no write strobes, go to FETCH.
  - From FETCH the timeout causes a re-fetch with the counter cleared. A `mem_ready` arriving in the same cycle as expiry wins.

## Timing
- State register and wait counter update on the rising edge of `clk`.
- Outputs decode combinationally from the state, plus `mem_ready` for the gated strobes.
- Latency with zero-wait memory, in cycles FETCH to done: R-type 4, lw 5, sw 4, beq 3, j 3.
- Each wait cycle adds 1 cycle.
- `rst_n` low at any time forces RESET immediately:
  - All outputs drop to 0 within the same cycle; an in-flight instruction is discarded with no write strobe.
  - The wait counter clears.
- `instr_done`, `illegal_op` and `mem_timeout` are never high together.

## Configuration
- `MC_JUMP_EN` defined: the JUMP state exists; opcode 000010 executes as a 3-cycle jump.
- `MC_JUMP_EN` undefined: the JUMP state is not compiled; opcode 000010 is treated as illegal, pulsing `illegal_op` and returning to FETCH.

## Test plan
- Reset, then `mem_ready`=1 constantly, R-type add (funct 100000) → states 1,2,7,8; `alu_control`=0010 in EXEC_R; `reg_write`=1 with `reg_dst`=1 in cycle 4; `instr_done` in cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEM_RD → 8 cycles total; `mem_read`=1 and `i_or_d`=1 held throughout the wait; `reg_write`=1 only in MEM_WB.
- beq → `alu_control`=0110, `pc_write_cond`=1, `pc_source`=01 in cycle 3, then back to FETCH.
- sw with `mem_ready` stuck 0 and WAIT_MAX=15 → `mem_write` high for 15 cycles, then one `mem_timeout` pulse, no `instr_done`, state returns to 1.
- Opcode 000010: with `MC_JUMP_EN`, `pc_write`=1 and `pc_source`=10 in cycle 3; without it, `illegal_op` pulses in DECODE and state goes to 1.
- `rst_n` pulled low mid-MEM_WB → `reg_write` drops immediately; state_o=0; after release the controller restarts at FETCH.
